// File: rtl/bus_pair_checker.sv
// bus_pair_checker: sink-side monitor for a pair of driven buses (o, oe).
// After start it ignores SETTLE_CYC cycles, then compares CHECK_CYC samples
// against EXP_O / EXP_OE. It counts bad samples, keeps the first bad one,
// and finishes with a one-cycle done plus a held pass verdict.
module bus_pair_checker #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXP_O      = 32'h00000001,
    parameter logic [WIDTH-1:0] EXP_OE     = 32'h00000001,
    parameter int               SETTLE_CYC = 2,
    parameter int               CHECK_CYC  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] o,
    input  logic [WIDTH-1:0] oe,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [7:0]       first_bad_idx,
    output logic [WIDTH-1:0] first_bad_o,
    output logic [WIDTH-1:0] first_bad_oe
);

    // Settle counter runs 0..SETTLE_CYC-1. The sample counter runs
    // 0..CHECK_CYC-1 and is at least 8 bits wide, so its low byte is the
    // reported sample index. That index wraps for runs longer than 256
    // samples, but the run still ends after exactly CHECK_CYC samples.
    localparam int SCW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
    localparam int CCW = (CHECK_CYC <= 256) ? 8 : $clog2(CHECK_CYC);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);
    localparam logic [CCW-1:0] CHECK_LAST  = CCW'(CHECK_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [SCW-1:0] settle_cnt;
    logic [CCW-1:0] sample_cnt;
    logic           sample_bad;
    logic [7:0]     err_inc;

    // Per-sample comparison and the saturating error increment.
    always_comb begin
        sample_bad = (o != EXP_O) || (oe != EXP_OE);
        err_inc    = (err_count == 8'hff) ? err_count : err_count + 8'd1;
    end

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, whatever order the always blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: abort wins over every other transition in SETTLE and CHECK.
    always_comb begin
        // NOTE: default first, so a path that misses an assignment holds
        // the current value instead of inferring a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (SETTLE_CYC == 0) ? CHECK : SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (sample_cnt == CHECK_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are decoded only from the state register, never from inputs.
    always_comb begin
        busy = (state == SETTLE) || (state == CHECK);
        done = (state == DONE);
    end

    // Run datapath: counters, error tally, first-bad capture and the verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt    <= '0;
            sample_cnt    <= '0;
            pass          <= 1'b0;
            err_count     <= 8'd0;
            first_bad_idx <= 8'd0;
            first_bad_o   <= '0;
            first_bad_oe  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        settle_cnt    <= '0;
                        sample_cnt    <= '0;
                        pass          <= 1'b0;
                        err_count     <= 8'd0;
                        first_bad_idx <= 8'd0;
                        first_bad_o   <= '0;
                        first_bad_oe  <= '0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SCW'(1);
                    end
                end
                CHECK: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        sample_cnt <= sample_cnt + CCW'(1);
                        if (sample_bad) begin
                            err_count <= err_inc;
                            // err_count saturates rather than wraps, so zero
                            // here always means "no mismatch yet in this run".
                            if (err_count == 8'd0) begin
                                first_bad_idx <= sample_cnt[7:0];
                                first_bad_o   <= o;
                                first_bad_oe  <= oe;
                            end
                        end
                        // The verdict is set with the last sample, so it is
                        // already valid in the done cycle.
                        if (sample_cnt == CHECK_LAST) begin
                            pass <= !sample_bad && (err_count == 8'd0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
